// File: rtl/inst_loop_ctrl_pkg.sv
// Shared types for the HDC instruction sequencer: loop modes, FSM states and
// the decode of the outermost active loop level.
package inst_loop_ctrl_pkg;

    localparam int unsigned NumLoops = 3;

    typedef enum logic [1:0] {
        LOOP_SINGLE = 2'd0,
        LOOP_DOUBLE = 2'd1,
        LOOP_TRIPLE = 2'd2
    } loop_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Reserved mode 3 falls back to a single loop.
    function automatic int unsigned outer_level(input logic [1:0] mode);
        case (mode)
            LOOP_DOUBLE: return 1;
            LOOP_TRIPLE: return 2;
            default:     return 0;
        endcase
    endfunction

endpackage

// File: rtl/inst_loop_ctrl_level_cnt.sv
// One hardware-loop level: iteration counter plus end-address match and
// exhaustion flags (a programmed count of 0 behaves as 1).
module loop_level_cnt #(
    parameter int unsigned InstAddrWidth = 8,
    parameter int unsigned LoopCntWidth  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     inc_i,
    input  logic [InstAddrWidth-1:0] pc_i,
    input  logic [InstAddrWidth-1:0] end_addr_i,
    input  logic [LoopCntWidth-1:0]  count_i,
    output logic                     match_o,
    output logic                     exhausted_o
);

    logic [LoopCntWidth-1:0] iter_q;
    logic [LoopCntWidth-1:0] last_iter;

    always_comb begin
        last_iter   = (count_i == '0) ? '0 : count_i - 1'b1;
        match_o     = (pc_i == end_addr_i);
        exhausted_o = (iter_q >= last_iter);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            iter_q <= '0;
        end else if (inc_i) begin
            iter_q <= iter_q + 1'b1;
        end
    end

endmodule

// File: rtl/inst_loop_ctrl.sv
// HDC instruction sequencer: PC generation with up to three nested hardware
// loops. Define INST_LOOP_STATUS_EN to add the retired_cnt_o handshake counter.
module inst_loop_ctrl
    import inst_loop_ctrl_pkg::*;
#(
    parameter int unsigned InstAddrWidth = 8,
    parameter int unsigned LoopCntWidth  = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic                               clr_i,
    input  logic [1:0]                         loop_mode_i,
    input  logic [2:0][InstAddrWidth-1:0]      loop_jump_addr_i,
    input  logic [2:0][InstAddrWidth-1:0]      loop_end_addr_i,
    input  logic [2:0][LoopCntWidth-1:0]       loop_count_i,
    output logic [InstAddrWidth-1:0]           pc_o,
    output logic                               inst_valid_o,
    input  logic                               inst_ready_i,
    output logic                               busy_o,
    output logic                               done_o
`ifdef INST_LOOP_STATUS_EN
    ,
    output logic [31:0]                        retired_cnt_o
`endif
);

    state_e                           state_q;
    logic [InstAddrWidth-1:0]         pc_q;
    logic [1:0]                       mode_q;
    logic [2:0][InstAddrWidth-1:0]    jump_q;
    logic [2:0][InstAddrWidth-1:0]    end_q;
    logic [2:0][LoopCntWidth-1:0]     count_q;

    logic                             start_go;
    logic                             handshake;
    logic                             reach;
    logic                             jump_taken;
    logic                             prog_end;
    logic [InstAddrWidth-1:0]         jump_pc;
    int unsigned                      outer;
    logic [NumLoops-1:0]              lvl_match;
    logic [NumLoops-1:0]              lvl_exh;
    logic [NumLoops-1:0]              lvl_inc;
    logic [NumLoops-1:0]              lvl_clr;

    for (genvar k = 0; k < NumLoops; k++) begin : g_level
        loop_level_cnt #(
            .InstAddrWidth(InstAddrWidth),
            .LoopCntWidth (LoopCntWidth)
        ) u_level (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clr_i      (lvl_clr[k]),
            .inc_i      (lvl_inc[k]),
            .pc_i       (pc_q),
            .end_addr_i (end_q[k]),
            .count_i    (count_q[k]),
            .match_o    (lvl_match[k]),
            .exhausted_o(lvl_exh[k])
        );
    end

    // Priority scan, innermost first: the first non-exhausted matching level
    // jumps; exhausted matching levels below it re-arm on the way.
    always_comb begin
        start_go   = (state_q == ST_IDLE) && start_i;
        handshake  = (state_q == ST_RUN) && inst_ready_i;
        outer      = outer_level(mode_q);
        reach      = 1'b1;
        jump_taken = 1'b0;
        jump_pc    = '0;
        lvl_inc    = '0;
        lvl_clr    = '0;
        for (int unsigned k = 0; k < NumLoops; k++) begin
            if (handshake && reach && (k <= outer) && lvl_match[k]) begin
                if (!lvl_exh[k]) begin
                    lvl_inc[k] = 1'b1;
                    jump_taken = 1'b1;
                    jump_pc    = jump_q[k];
                    reach      = 1'b0;
                end else begin
                    lvl_clr[k] = 1'b1;
                end
            end
        end
        for (int unsigned k = 0; k < NumLoops; k++) begin
            for (int unsigned j = k + 1; j < NumLoops; j++) begin
                if (lvl_inc[j]) lvl_clr[k] = 1'b1;
            end
            if (clr_i || start_go) lvl_clr[k] = 1'b1;
        end
        prog_end = handshake && !jump_taken && lvl_match[outer];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            mode_q  <= '0;
            jump_q  <= '0;
            end_q   <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        pc_q    <= '0;
                        mode_q  <= loop_mode_i;
                        jump_q  <= loop_jump_addr_i;
                        end_q   <= loop_end_addr_i;
                        count_q <= loop_count_i;
                    end
                end
                ST_RUN: begin
                    if (prog_end) begin
                        state_q <= ST_DONE;
                    end else if (handshake) begin
                        pc_q <= jump_taken ? jump_pc : pc_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_o         = pc_q;
        inst_valid_o = (state_q == ST_RUN);
        busy_o       = (state_q == ST_RUN);
        done_o       = (state_q == ST_DONE);
    end

`ifdef INST_LOOP_STATUS_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i || start_go) begin
            retired_q <= '0;
        end else if (handshake && (retired_q != '1)) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign retired_cnt_o = retired_q;
`endif

endmodule

// File: tb/tb_inst_loop_ctrl.sv
// Self-checking bench for inst_loop_ctrl: table of loop configurations with
// their expected PC streams, scoreboarded per handshake, plus corner sequences.
module tb_inst_loop_ctrl;

    localparam int NV = 6;

    typedef struct {
        logic [1:0]      mode;
        logic [2:0][7:0] jmp;
        logic [2:0][7:0] endd;
        logic [2:0][7:0] cnt;
        int              len;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            start_i;
    logic            clr_i;
    logic [1:0]      loop_mode_i;
    logic [2:0][7:0] loop_jump_addr_i;
    logic [2:0][7:0] loop_end_addr_i;
    logic [2:0][7:0] loop_count_i;
    logic [7:0]      pc_o;
    logic            inst_valid_o;
    logic            inst_ready_i;
    logic            busy_o;
    logic            done_o;
`ifdef INST_LOOP_STATUS_EN
    logic [31:0]     retired_cnt_o;
`endif

    vec_t       tab [NV];
    int         seq_tab [NV][16];
    logic [7:0] exp_q [$];
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    inst_loop_ctrl #(
        .InstAddrWidth(8),
        .LoopCntWidth (8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .clr_i           (clr_i),
        .loop_mode_i     (loop_mode_i),
        .loop_jump_addr_i(loop_jump_addr_i),
        .loop_end_addr_i (loop_end_addr_i),
        .loop_count_i    (loop_count_i),
        .pc_o            (pc_o),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .busy_o          (busy_o),
        .done_o          (done_o)
`ifdef INST_LOOP_STATUS_EN
        ,
        .retired_cnt_o   (retired_cnt_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic setv(input int i, input logic [1:0] mode, input logic [23:0] jmp,
                        input logic [23:0] endd, input logic [23:0] cnt, input int len);
        tab[i].mode = mode;
        tab[i].jmp  = jmp;
        tab[i].endd = endd;
        tab[i].cnt  = cnt;
        tab[i].len  = len;
    endtask

    task automatic start_pulse();
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
    endtask

    // Pops one expected PC per observed handshake; optionally stalls at pc 3
    // and optionally checks the done pulse after the last handshake.
    task automatic drain(input bit bp, input bit fin);
        int         cyc = 0;
        bit         bp_done = 1'b0;
        logic [7:0] e;
        while (exp_q.size() > 0 && cyc < 500) begin
            if (bp && !bp_done && inst_valid_o && pc_o == 8'd3) begin
                inst_ready_i = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    cyc++;
                    check("bp_pc_hold", 32'(pc_o), 32'd3);
                    check("bp_valid_hold", 32'(inst_valid_o), 32'd1);
                end
                inst_ready_i = 1'b1;
                bp_done = 1'b1;
            end
            if (inst_valid_o && inst_ready_i) begin
                e = exp_q.pop_front();
                check("pc", 32'(pc_o), 32'(e));
            end
            @(negedge clk);
            cyc++;
        end
        check("handshake_timeout_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (fin) begin
            check("done_pulse", 32'(done_o), 32'd1);
            check("valid_after_end", 32'(inst_valid_o), 32'd0);
            check("busy_after_end", 32'(busy_o), 32'd0);
            @(negedge clk);
            check("done_one_cycle", 32'(done_o), 32'd0);
        end
    endtask

    task automatic load_cfg(input int v);
        loop_mode_i      = tab[v].mode;
        loop_jump_addr_i = tab[v].jmp;
        loop_end_addr_i  = tab[v].endd;
        loop_count_i     = tab[v].cnt;
    endtask

    task automatic scramble_cfg();
        loop_mode_i      = 2'($urandom);
        loop_jump_addr_i = 24'($urandom);
        loop_end_addr_i  = 24'($urandom);
        loop_count_i     = 24'($urandom);
    endtask

    task automatic run_vec(input int v, input bit bp);
        load_cfg(v);
        for (int j = 0; j < tab[v].len; j++) exp_q.push_back(8'(seq_tab[v][j]));
        start_pulse();
        check("busy_at_start", 32'(busy_o), 32'd1);
        check("valid_at_start", 32'(inst_valid_o), 32'd1);
        scramble_cfg();
        drain(bp, 1'b1);
    endtask

    initial begin
        // Packed level order is {level2, level1, level0}.
        setv(0, 2'd0, {8'd0, 8'd0, 8'd2},   {8'd0, 8'd0, 8'd4}, {8'd0, 8'd0, 8'd3}, 11);
        seq_tab[0] = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 0, 0, 0, 0, 0};
        setv(1, 2'd1, {8'd0, 8'd0, 8'd1},   {8'd0, 8'd3, 8'd2}, {8'd0, 8'd2, 8'd2}, 12);
        seq_tab[1] = '{0, 1, 2, 1, 2, 3, 0, 1, 2, 1, 2, 3, 0, 0, 0, 0};
        setv(2, 2'd2, {8'd0, 8'd0, 8'd0},   {8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2}, 16);
        seq_tab[2] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        setv(3, 2'd0, {8'd0, 8'd0, 8'd0},   {8'd0, 8'd0, 8'd2}, {8'd0, 8'd0, 8'd0}, 3);
        seq_tab[3] = '{0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        setv(4, 2'd3, {8'd0, 8'd0, 8'd2},   {8'd1, 8'd1, 8'd4}, {8'd5, 8'd5, 8'd3}, 11);
        seq_tab[4] = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 0, 0, 0, 0, 0};
        setv(5, 2'd0, {8'd0, 8'd0, 8'd254}, {8'd0, 8'd0, 8'd2}, {8'd0, 8'd0, 8'd2}, 8);
        seq_tab[5] = '{0, 1, 2, 254, 255, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0};

        rst_ni       = 1'b0;
        start_i      = 1'b0;
        clr_i        = 1'b0;
        inst_ready_i = 1'b1;
        scramble_cfg();
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check("reset_pc", 32'(pc_o), 32'd0);
        check("reset_valid", 32'(inst_valid_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);

        for (int v = 0; v < NV; v++) run_vec(v, 1'b0);
`ifdef INST_LOOP_STATUS_EN
        check("retired_cnt", retired_cnt_o, 32'd8);
`endif

        run_vec(0, 1'b1);

        // clr_i at pc 3 together with a start pulse; clear must win.
        load_cfg(0);
        for (int j = 0; j < 3; j++) exp_q.push_back(8'(seq_tab[0][j]));
        start_pulse();
        drain(1'b0, 1'b0);
        check("clr_pre_pc", 32'(pc_o), 32'd3);
        clr_i   = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        clr_i   = 1'b0;
        start_i = 1'b0;
        check("clr_valid", 32'(inst_valid_o), 32'd0);
        check("clr_busy", 32'(busy_o), 32'd0);
        check("clr_done", 32'(done_o), 32'd0);
        check("clr_pc", 32'(pc_o), 32'd0);
        @(negedge clk);
        check("clr_done_after", 32'(done_o), 32'd0);
        check("clr_stays_idle", 32'(busy_o), 32'd0);

        run_vec(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
